// File: rtl/pe_buffer_replay_reader_if.sv
// Handshake/bus bundle between the PE input buffer, the replay reader and the PE array.
// STALL_COUNT exists only when PE_REPLAY_STALL_CNT_EN is defined.
interface pe_buffer_replay_reader_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 9,
    parameter int LEN_WIDTH   = 8,
    parameter int REP_WIDTH   = 8
);
    logic                   CFG_VALID;
    logic                   CFG_READY;
    logic [LEN_WIDTH-1:0]   CFG_LEN;
    logic [REP_WIDTH-1:0]   CFG_REPEAT;
    logic                   BUF_POP;
    logic                   BUF_SAVE_RD_ADDR;
    logic                   BUF_RESTORE_RD_ADDR;
    logic                   BUF_EMPTY;
    logic [COUNT_WIDTH-1:0] BUF_COUNT;
    logic [DATA_WIDTH-1:0]  BUF_DATA;
    logic [DATA_WIDTH-1:0]  PE_DATA;
    logic                   PE_LAST;
    logic                   PE_VALID;
    logic                   PE_READY;
    logic                   DONE;
    logic [1:0]             DBG_STATE;
`ifdef PE_REPLAY_STALL_CNT_EN
    logic [31:0]            STALL_COUNT;
`endif

    modport master (
        input  CFG_VALID, CFG_LEN, CFG_REPEAT, BUF_EMPTY, BUF_COUNT, BUF_DATA, PE_READY,
`ifdef PE_REPLAY_STALL_CNT_EN
        output STALL_COUNT,
`endif
        output CFG_READY, BUF_POP, BUF_SAVE_RD_ADDR, BUF_RESTORE_RD_ADDR,
        output PE_DATA, PE_LAST, PE_VALID, DONE, DBG_STATE
    );

    modport slave (
        output CFG_VALID, CFG_LEN, CFG_REPEAT, BUF_EMPTY, BUF_COUNT, BUF_DATA, PE_READY,
`ifdef PE_REPLAY_STALL_CNT_EN
        input  STALL_COUNT,
`endif
        input  CFG_READY, BUF_POP, BUF_SAVE_RD_ADDR, BUF_RESTORE_RD_ADDR,
        input  PE_DATA, PE_LAST, PE_VALID, DONE, DBG_STATE
    );
endinterface

// File: rtl/pe_buffer_replay_reader.sv
// Replay reader for the PE input buffer: pops a CFG_LEN window, rewinds it CFG_REPEAT times.
// Optional PE_REPLAY_STALL_CNT_EN adds a saturating empty-buffer stall counter.
module pe_buffer_replay_reader #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 9,
    parameter int LEN_WIDTH   = 8,
    parameter int REP_WIDTH   = 8
) (
    input logic CLK,
    input logic RESET,
    pe_buffer_replay_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REWIND = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, word_cnt_q;
    logic [REP_WIDTH-1:0]  rep_q, pass_cnt_q;
    logic                  zero_done_q;
    logic                  inflight_q, inflight_last_q;
    logic [1:0]            skid_occ_q;
    logic [DATA_WIDTH-1:0] skid_data_q [2];
    logic                  skid_last_q [2];

    logic       cfg_accept, cfg_zero, buf_has_data, room, pop;
    logic       word_last, pass_last, pe_valid, drain, drain_skid, in_write, drained;
    logic       save, restore;
    logic [1:0] occ_shift, occ_next;

    // PE stream: a word transfers on a cycle with PE_VALID && PE_READY; once PE_VALID
    // rises it stays high with PE_DATA/PE_LAST frozen until that transfer happens.
    assign pe_valid     = (skid_occ_q != 2'd0) || inflight_q;
    assign drain        = pe_valid && bus.PE_READY;
    assign drain_skid   = drain && (skid_occ_q != 2'd0);
    assign in_write     = inflight_q && !(drain && (skid_occ_q == 2'd0));
    assign occ_shift    = skid_occ_q - {1'b0, drain_skid};
    assign occ_next     = occ_shift + {1'b0, in_write};
    assign drained      = !inflight_q && (skid_occ_q == 2'd0);

    // The count cross-check keeps a stale empty flag from launching a pop into nothing.
    assign buf_has_data = !bus.BUF_EMPTY && (bus.BUF_COUNT != '0);
    assign room         = ({1'b0, skid_occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, drain});
    assign pop          = (state_q == RUN) && buf_has_data && room;
    assign word_last    = (word_cnt_q == len_q - LEN_WIDTH'(1));
    assign pass_last    = (pass_cnt_q == rep_q - REP_WIDTH'(1));
    assign save         = pop && (word_cnt_q == '0) && (pass_cnt_q == '0);
    assign cfg_accept   = (state_q == IDLE) && bus.CFG_VALID;
    assign cfg_zero     = (bus.CFG_LEN == '0) || (bus.CFG_REPEAT == '0);

    always_comb begin
        state_d = state_q;
        restore = 1'b0;
        case (state_q)
            IDLE:    if (cfg_accept && !cfg_zero) state_d = RUN;
            RUN:     if (pop && word_last) state_d = pass_last ? DRAIN : REWIND;
            REWIND: begin
                restore = 1'b1;
                state_d = RUN;
            end
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            len_q           <= '0;
            rep_q           <= '0;
            word_cnt_q      <= '0;
            pass_cnt_q      <= '0;
            zero_done_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            zero_done_q     <= cfg_accept && cfg_zero;
            inflight_q      <= pop;
            inflight_last_q <= pop && word_last;
            if (cfg_accept) begin
                len_q      <= bus.CFG_LEN;
                rep_q      <= bus.CFG_REPEAT;
                word_cnt_q <= '0;
                pass_cnt_q <= '0;
            end else if (state_q == REWIND) begin
                word_cnt_q <= '0;
                pass_cnt_q <= pass_cnt_q + REP_WIDTH'(1);
            end else if (pop && !word_last) begin
                word_cnt_q <= word_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // Skid FIFO: head leaves on drain, the word returning from the buffer lands behind it.
    // A returning word consumed straight off BUF_DATA never enters the skid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            skid_occ_q     <= 2'd0;
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_last_q[0] <= 1'b0;
            skid_last_q[1] <= 1'b0;
        end else begin
            if (drain_skid) begin
                skid_data_q[0] <= skid_data_q[1];
                skid_last_q[0] <= skid_last_q[1];
            end
            if (in_write) begin
                if (occ_shift == 2'd0) begin
                    skid_data_q[0] <= bus.BUF_DATA;
                    skid_last_q[0] <= inflight_last_q;
                end else begin
                    skid_data_q[1] <= bus.BUF_DATA;
                    skid_last_q[1] <= inflight_last_q;
                end
            end
            skid_occ_q <= occ_next;
        end
    end

    assign bus.PE_VALID            = pe_valid;
    assign bus.PE_DATA             = (skid_occ_q != 2'd0) ? skid_data_q[0] :
                                     (inflight_q ? bus.BUF_DATA : '0);
    assign bus.PE_LAST             = (skid_occ_q != 2'd0) ? skid_last_q[0] :
                                     (inflight_q && inflight_last_q);
    assign bus.CFG_READY           = (state_q == IDLE);
    assign bus.BUF_POP             = pop;
    assign bus.BUF_SAVE_RD_ADDR    = save;
    assign bus.BUF_RESTORE_RD_ADDR = restore;
    assign bus.DONE                = ((state_q == DRAIN) && drained) || zero_done_q;
    assign bus.DBG_STATE           = state_q;

`ifdef PE_REPLAY_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET || cfg_accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) && !buf_has_data && room && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.STALL_COUNT = stall_cnt_q;
`endif

endmodule

// File: doc/pe_buffer_replay_reader.md
Name: pe_buffer_replay_reader

Overview:
- Read-side sequencer for the PE input buffer FIFO, i.e. the reader that drives its POP / SAVE_RD_ADDR / RESTORE_RD_ADDR controls.
- Per job, reads a window of CFG_LEN words and replays it CFG_REPEAT times, using the buffer's read-pointer checkpoint/restore.
- Absorbs the buffer's 1-cycle read latency and presents a valid/ready stream to the PE array through a 2-entry skid.

Parameters:
- DATA_WIDTH, 64, buffer/PE data width.
- COUNT_WIDTH, 9, width of the buffer occupancy count (buffer ADDR_WIDTH+1).
- LEN_WIDTH, 8, width of the window-length config.
- REP_WIDTH, 8, width of the repeat-count config.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- CFG_VALID  in  1  job request.
- CFG_READY  out  1  high only in IDLE.
- CFG_LEN  in  LEN_WIDTH  words per pass.
- CFG_REPEAT  in  REP_WIDTH  number of passes.
- BUF_POP  out  1  buffer pop.
- BUF_SAVE_RD_ADDR  out  1  checkpoint the buffer read pointer and count.
- BUF_RESTORE_RD_ADDR  out  1  rewind to the checkpoint.
- BUF_EMPTY  in  1  buffer empty flag.
- BUF_COUNT  in  COUNT_WIDTH  buffer occupancy (status only).
- BUF_DATA  in  DATA_WIDTH  buffer DATA_OUT; valid 1 cycle after BUF_POP.
- PE_DATA  out  DATA_WIDTH  stream data.
- PE_LAST  out  1  marks the last word of each pass.
- PE_VALID  out  1  stream valid.
- PE_READY  in  1  stream ready.
- DONE  out  1  1-cycle pulse at job end.

Behaviour:
- Reset: state IDLE; CFG_READY=1; BUF_POP, BUF_SAVE_RD_ADDR, BUF_RESTORE_RD_ADDR, PE_VALID, PE_LAST, DONE = 0; PE_DATA = 0. Skid, in-flight flag, word_cnt and pass_cnt cleared.
- Reset mid-job: the in-flight word is discarded; the buffer must be reset alongside.
- FSM states: IDLE, RUN, REWIND, DRAIN.
- IDLE, on CFG_VALID:
  - Latch len and rep; go to RUN.
  - If CFG_LEN==0 or CFG_REPEAT==0: no buffer activity; DONE pulses the next cycle; stay IDLE.
- RUN, pop condition: BUF_POP = !BUF_EMPTY && (skid_occ + inflight − drain) < 2.
  - drain = PE_VALID && PE_READY.
  - inflight = BUF_POP registered.
- RUN, first pop of the job (pass 0, word 0) asserts BUF_SAVE_RD_ADDR in the same cycle. SAVE is never asserted again within the job.
- RUN, pass end: each pop increments word_cnt. The pop with word_cnt==len−1 tags the word last.
  - If pass_cnt==rep−1, go to DRAIN.
  - Otherwise go to REWIND.
- REWIND: exactly one cycle.
  - BUF_RESTORE_RD_ADDR=1, BUF_POP=0. RESTORE never coincides with POP.
  - word_cnt=0, pass_cnt+1, then back to RUN.
- DRAIN: wait for inflight==0 and skid empty; then DONE=1 for one cycle and go to IDLE.
- Capture and output order:
  - The cycle after a pop, BUF_DATA and the last tag are written into the skid.
  - The skid head drives PE_DATA/PE_LAST/PE_VALID.
  - Order is FIFO; the skid never overflows (guaranteed by the pop condition).
- Stream rules: PE_VALID, once high, holds with stable PE_DATA/PE_LAST until PE_READY.
- Latency: pop to PE_VALID = 1 cycle when the skid is empty.
- Throughput: 1 word/cycle with PE_READY=1 and the buffer non-empty. Each rewind costs 1 bubble.
- BUF_EMPTY during RUN: pops stall; no state change.
- Counters: width-exact compares; word_cnt and pass_cnt never wrap because they end at len−1 and rep−1.
- CFG_VALID outside IDLE: ignored.

Optional Feature:
- Macro: PE_REPLAY_STALL_CNT_EN.
- With the macro defined:
  - Extra output STALL_COUNT [31:0], cleared by RESET and at job accept.
  - Increments (saturating) in every RUN cycle where BUF_EMPTY=1 blocks a pop.
- Without the macro: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Buffer preloaded 0x10..0x13, LEN=4, REPEAT=3, PE_READY=1 -> PE sees 0x10..0x13 ×3 (12 words) with PE_LAST on words 4, 8, 12. SAVE in pop cycle 1; RESTORE twice, never with POP; DONE 1 cycle after the last word drains.
- Same job, PE_READY toggling 1,0,0,1 -> no word lost or duplicated; PE_DATA stable while stalled; at most 2 pops outstanding.
- LEN=3, REPEAT=1, buffer initially empty; push 0xA,0xB,0xC one every 4 cycles -> one pop per push; PE sees A,B,C with PE_LAST on C; no RESTORE; STALL_COUNT (if enabled) = 7.
- CFG_LEN=0, REPEAT=5 -> no POP/SAVE/RESTORE; DONE the cycle after accept; CFG_READY stays 1.
- RESET asserted mid-pass 2 of LEN=4, REPEAT=3 -> next cycle all outputs 0, CFG_READY=1. A fresh LEN=2, REPEAT=2 job after buffer reload then runs correctly.
- CFG_VALID pulsed during RUN with different LEN -> ignored; the original job completes unchanged.
